// File: rtl/reduce_inject_arb_pkg.sv
// Shared flit field constants and arbiter types for the reduce/inject path.
// Flit layout: [valid | 49-bit header | payload], children above the valid bit.
package reduce_inject_arb_pkg;

  localparam int DefLgNumprocs   = 3;
  localparam int DefPayloadWidth = 32;
  localparam int DefQDepth       = 4;
  localparam int HdrWidth        = 50;
  localparam int AlgTypeWidth    = 2;

  function automatic int flit_width(input int pw);
    return pw + HdrWidth;
  endfunction

  function automatic int valid_bit_pos(input int pw);
    return pw + HdrWidth - 1;
  endfunction

  function automatic int flit_child_width(input int pw, input int lg);
    return pw + HdrWidth + lg;
  endfunction

  function automatic int alg_type_pos(input int pw);
    return pw + HdrWidth - 1 - AlgTypeWidth;
  endfunction

  localparam int FlitWidth      = flit_width(DefPayloadWidth);
  localparam int ValidBitPos    = valid_bit_pos(DefPayloadWidth);
  localparam int FlitChildWidth = flit_child_width(DefPayloadWidth,
                                                   DefLgNumprocs);
  localparam int AlgTypePos     = alg_type_pos(DefPayloadWidth);

  typedef enum logic [2:0] {
    PRI_X   = 3'b001,
    PRI_Y   = 3'b010,
    PRI_APP = 3'b100
  } pri_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_X    = 2'd1,
    SRC_Y    = 2'd2,
    SRC_APP  = 2'd3
  } src_e;

endpackage

// File: rtl/reduce_inject_arb_if.sv
// Bundle of reduce inputs, application injection handshake and router port.
// slave is the arbiter's view, master is the environment's view.
interface reduce_inject_arb_if
  import reduce_inject_arb_pkg::*;
#(
    parameter int FW  = FlitWidth,
    parameter int FCW = FlitChildWidth
);

    logic [FW-1:0]  red_x_flit;
    logic           red_x_valid;
    logic [FW-1:0]  red_y_flit;
    logic           red_y_valid;
    logic [FCW-1:0] app_flit;
    logic           app_valid;
    logic           app_ready;
    logic           inj_stall;
    logic [FCW-1:0] inj_flit;
    logic [1:0]     ovf_err;

    modport slave (
        input  red_x_flit,
        input  red_x_valid,
        input  red_y_flit,
        input  red_y_valid,
        input  app_flit,
        input  app_valid,
        input  inj_stall,
        output app_ready,
        output inj_flit,
        output ovf_err
    );

    modport master (
        output red_x_flit,
        output red_x_valid,
        output red_y_flit,
        output red_y_valid,
        output app_flit,
        output app_valid,
        output inj_stall,
        input  app_ready,
        input  inj_flit,
        input  ovf_err
    );

endinterface

// File: rtl/reduce_inject_arb_result_queue.sv
// Small FIFO buffering reduce-unit results; drops writes when full and
// raises a sticky overflow flag.
module result_queue #(
    parameter int Width = 82,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [Width-1:0] rd_data_o,
    output logic             empty_o,
    output logic             ovf_o
);

    localparam int AW = $clog2(Depth);
    localparam logic [AW:0] Full = (AW+1)'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full, push, pop;

    assign full    = (count_q == Full);
    assign empty_o = (count_q == '0);
    assign push    = wr_valid_i && !full;
    assign pop     = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        if (wr_valid_i && full) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign ovf_o     = ovf_q;

endmodule

// File: rtl/reduce_inject_arb.sv
// Merges x/y reduce results and application flits onto the router inject
// port with a rotating-priority arbiter and a registered output.
module reduce_inject_arb
  import reduce_inject_arb_pkg::*;
#(
    parameter int lg_numprocs  = DefLgNumprocs,
    parameter int PayloadWidth = DefPayloadWidth,
    parameter int QDepth       = DefQDepth
) (
    input  logic                 clk,
    input  logic                 rst,
    reduce_inject_arb_if.slave   bus
);

    localparam int FW  = flit_width(PayloadWidth);
    localparam int FCW = flit_child_width(PayloadWidth, lg_numprocs);
    localparam int VB  = valid_bit_pos(PayloadWidth);
    localparam logic [FCW-1:0] VbMask = FCW'(1) << VB;

    logic [FW-1:0]  x_data, y_data;
    logic           x_empty, y_empty;
    logic           x_ovf, y_ovf;
    pri_e           state_q, state_d;
    src_e           gnt;
    logic [FCW-1:0] flit_d, inj_flit_q;

    result_queue #(.Width(FW), .Depth(QDepth)) u_xq (
        .clk        (clk),
        .rst        (rst),
        .wr_valid_i (bus.red_x_valid),
        .wr_data_i  (bus.red_x_flit),
        .rd_en_i    (gnt == SRC_X),
        .rd_data_o  (x_data),
        .empty_o    (x_empty),
        .ovf_o      (x_ovf)
    );

    result_queue #(.Width(FW), .Depth(QDepth)) u_yq (
        .clk        (clk),
        .rst        (rst),
        .wr_valid_i (bus.red_y_valid),
        .wr_data_i  (bus.red_y_flit),
        .rd_en_i    (gnt == SRC_Y),
        .rd_data_o  (y_data),
        .empty_o    (y_empty),
        .ovf_o      (y_ovf)
    );

    always_comb begin
        gnt     = SRC_NONE;
        state_d = state_q;
        if (!bus.inj_stall && !rst) begin
            unique case (1'b1)
                (state_q == PRI_X): begin
                    if (!x_empty)           gnt = SRC_X;
                    else if (!y_empty)      gnt = SRC_Y;
                    else if (bus.app_valid) gnt = SRC_APP;
                end
                (state_q == PRI_Y): begin
                    if (!y_empty)           gnt = SRC_Y;
                    else if (bus.app_valid) gnt = SRC_APP;
                    else if (!x_empty)      gnt = SRC_X;
                end
                (state_q == PRI_APP): begin
                    if (bus.app_valid)      gnt = SRC_APP;
                    else if (!x_empty)      gnt = SRC_X;
                    else if (!y_empty)      gnt = SRC_Y;
                end
                default: gnt = SRC_NONE;
            endcase
        end
        unique case (gnt)
            SRC_X:   state_d = PRI_Y;
            SRC_Y:   state_d = PRI_APP;
            SRC_APP: state_d = PRI_X;
            default: state_d = state_q;
        endcase
    end

    // Reduce flits are zero-extended (children 0); every granted flit is valid.
    always_comb begin
        flit_d = '0;
        unique case (gnt)
            SRC_X:   flit_d = FCW'(x_data) | VbMask;
            SRC_Y:   flit_d = FCW'(y_data) | VbMask;
            SRC_APP: flit_d = bus.app_flit | VbMask;
            default: flit_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PRI_X;
            inj_flit_q <= '0;
        end else begin
            state_q    <= state_d;
            inj_flit_q <= flit_d;
        end
    end

    assign bus.inj_flit  = inj_flit_q;
    assign bus.app_ready = (gnt == SRC_APP);
    assign bus.ovf_err   = {y_ovf, x_ovf};

endmodule

// File: tb/tb_reduce_inject_arb.sv
// Directed bench for reduce_inject_arb: latency, rotation order, overflow,
// depth boundary, mid-run reset and stall gating of application grants.
module tb_reduce_inject_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    reduce_inject_arb_if #(.FW(82), .FCW(85)) bus ();

    reduce_inject_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [81:0] rflit(input logic [31:0] p);
        return {1'b0, 17'h1A5C3, ~p, p};
    endfunction

    function automatic logic [84:0] exp_red(input logic [81:0] f);
        return {3'b000, 1'b1, f[80:0]};
    endfunction

    localparam logic [84:0] AF  = {3'b101, 1'b1, 17'h0ABCD,
                                   32'h12345678, 32'hCAFEF00D};
    localparam logic [84:0] AF2 = {3'b011, 1'b1, 17'h15555,
                                   32'h0F0F0F0F, 32'h76543210};

    logic [84:0] seq [6];
    logic        stl [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.red_x_flit  = '0;
        bus.red_x_valid = 1'b0;
        bus.red_y_flit  = '0;
        bus.red_y_valid = 1'b0;
        bus.app_flit    = '0;
        bus.app_valid   = 1'b0;
        bus.inj_stall   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_inj", bus.inj_flit, 0);
        check("rst_ready", bus.app_ready, 0);
        check("rst_ovf", bus.ovf_err, 0);
        rst = 1'b0;
        tick();

        // single x result: two-cycle latency, exactly one output cycle
        bus.red_x_flit  = rflit(32'hDEADBEEF);
        bus.red_x_valid = 1'b1;
        tick();
        bus.red_x_valid = 1'b0;
        check("x1_early", bus.inj_flit, 0);
        tick();
        check("x1_out", bus.inj_flit, exp_red(rflit(32'hDEADBEEF)));
        tick();
        check("x1_once", bus.inj_flit, 0);

        // all three requesting: X,Y,APP,X,Y,APP
        do_reset();
        bus.inj_stall   = 1'b1;
        bus.red_x_flit  = rflit(32'h00000011);
        bus.red_y_flit  = rflit(32'h00000021);
        bus.red_x_valid = 1'b1;
        bus.red_y_valid = 1'b1;
        tick();
        bus.red_x_flit  = rflit(32'h00000012);
        bus.red_y_flit  = rflit(32'h00000022);
        tick();
        bus.red_x_valid = 1'b0;
        bus.red_y_valid = 1'b0;
        bus.inj_stall   = 1'b0;
        bus.app_flit    = AF;
        bus.app_valid   = 1'b1;
        seq[0] = exp_red(rflit(32'h00000011));
        seq[1] = exp_red(rflit(32'h00000021));
        seq[2] = AF;
        seq[3] = exp_red(rflit(32'h00000012));
        seq[4] = exp_red(rflit(32'h00000022));
        seq[5] = AF;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("rr_ready%0d", k), bus.app_ready,
                  (k == 2 || k == 5) ? 1 : 0);
            if (k > 0)
                check($sformatf("rr_out%0d", k - 1), bus.inj_flit, seq[k-1]);
            tick();
        end
        check("rr_out5", bus.inj_flit, seq[5]);
        bus.app_valid = 1'b0;
        tick();
        check("rr_idle", bus.inj_flit, 0);

        // y overflow under stall, then drain in order
        bus.inj_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.red_y_flit  = rflit(32'h100 + i);
            bus.red_y_valid = 1'b1;
            tick();
        end
        bus.red_y_valid = 1'b0;
        check("ovf_y", bus.ovf_err, 2'b10);
        check("ovf_stall_out", bus.inj_flit, 0);
        bus.inj_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("ovf_drain%0d", i), bus.inj_flit,
                  exp_red(rflit(32'h100 + i)));
        end
        tick();
        check("ovf_drained", bus.inj_flit, 0);

        // depth 3 with simultaneous write and read keeps depth 3
        do_reset();
        bus.inj_stall   = 1'b1;
        bus.red_x_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.red_x_flit = rflit(32'h200 + i);
            tick();
        end
        bus.inj_stall  = 1'b0;
        bus.red_x_flit = rflit(32'h203);
        tick();
        check("d3_out0", bus.inj_flit, exp_red(rflit(32'h200)));
        bus.inj_stall  = 1'b1;
        bus.red_x_flit = rflit(32'h204);
        tick();
        check("d3_no_ovf", bus.ovf_err, 0);
        check("d3_stall_out", bus.inj_flit, 0);
        bus.red_x_flit = rflit(32'h205);
        tick();
        check("d3_full_ovf", bus.ovf_err, 2'b01);
        bus.red_x_valid = 1'b0;
        bus.inj_stall   = 1'b0;
        for (int i = 1; i < 5; i++) begin
            tick();
            check($sformatf("d3_out%0d", i), bus.inj_flit,
                  exp_red(rflit(32'h200 + i)));
        end

        // reset with flits queued discards them and restarts at PRI_X
        bus.inj_stall   = 1'b1;
        bus.red_x_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.red_x_flit = rflit(32'h300 + i);
            tick();
        end
        bus.red_x_valid = 1'b0;
        rst           = 1'b1;
        bus.app_valid = 1'b1;
        #1;
        check("mid_rst_inj", bus.inj_flit, 0);
        check("mid_rst_ovf", bus.ovf_err, 0);
        check("mid_rst_ready", bus.app_ready, 0);
        tick();
        rst           = 1'b0;
        bus.app_valid = 1'b0;
        bus.inj_stall = 1'b0;
        tick();
        check("post_rst_quiet0", bus.inj_flit, 0);
        tick();
        check("post_rst_quiet1", bus.inj_flit, 0);
        bus.inj_stall   = 1'b1;
        bus.red_x_flit  = rflit(32'h400);
        bus.red_y_flit  = rflit(32'h401);
        bus.red_x_valid = 1'b1;
        bus.red_y_valid = 1'b1;
        tick();
        bus.red_x_valid = 1'b0;
        bus.red_y_valid = 1'b0;
        bus.inj_stall   = 1'b0;
        tick();
        check("post_rst_first_x", bus.inj_flit, exp_red(rflit(32'h400)));
        tick();
        check("post_rst_then_y", bus.inj_flit, exp_red(rflit(32'h401)));

        // app held while stall toggles
        stl[0] = 1'b1;
        stl[1] = 1'b0;
        stl[2] = 1'b1;
        stl[3] = 1'b0;
        bus.app_flit  = AF2;
        bus.app_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.inj_stall = stl[k];
            #1;
            check($sformatf("stall_ready%0d", k), bus.app_ready,
                  stl[k] ? 0 : 1);
            tick();
            check($sformatf("stall_out%0d", k), bus.inj_flit,
                  stl[k] ? 85'd0 : AF2);
        end
        bus.app_valid = 1'b0;
        bus.inj_stall = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
